quad_updown_decoder: RTL

- Converts a two-phase quadrature input (qa, qb) into step/direction events and an 8-bit wrap-around position count.
- The 8-bit up-down counter consumes a direction bit (ud) and a count enable. This block produces that direction bit from an external encoder.
- It is the front end that feeds the team's up-down counter datapath.
- Its own count output is a reference copy of the position, used for self-check in lab benches.

---
 rtl/quad_updown_decoder.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/quad_updown_decoder.sv
// rtl/quad_updown_decoder.sv - quadrature to step/direction decoder with 8-bit position count
// Optional per-phase glitch filter: define QDEC_FILTER_EN.
module quad_updown_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       qa,
  input  logic       qb,
  input  logic       clr,
  output logic       step,
  output logic       ud,
  output logic [7:0] count,
  output logic       err
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("SYNC_STAGES must be 2..4");
  end
  if (FILT_LEN < 2 || FILT_LEN > 8) begin : g_bad_filt_len
    $error("FILT_LEN must be 2..8");
  end

  typedef enum logic {ST_PRIME, ST_TRACK} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             prime_cnt_q, prime_cnt_d;
  logic [SYNC_STAGES-1:0] qa_sync_q, qa_sync_d;
  logic [SYNC_STAGES-1:0] qb_sync_q, qb_sync_d;
  logic [1:0]             p_q, p_d;
  logic                   step_q, step_d;
  logic                   ud_q, ud_d;
  logic [7:0]             count_q, count_d;
  logic                   err_q, err_d;
  logic [1:0]             raw_s;
  logic [1:0]             s;
  logic [1:0]             diff;
  logic                   dir_up;
  logic                   load_p;
  logic                   decode_en;

  // Synchroniser chains: shift the asynchronous phases in one stage per clock
  always_comb begin
    qa_sync_d = {qa_sync_q[SYNC_STAGES-2:0], qa};
    qb_sync_d = {qb_sync_q[SYNC_STAGES-2:0], qb};
    raw_s     = {qa_sync_q[SYNC_STAGES-1], qb_sync_q[SYNC_STAGES-1]};
  end

`ifdef QDEC_FILTER_EN
  logic [1:0]      filt_q, filt_d;
  logic [1:0][3:0] fcnt_q, fcnt_d;

  // Glitch filter: a phase flips only after FILT_LEN consecutive differing samples;
  // while priming it tracks the raw sample so a resting encoder is not seen as moving
  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    for (int i = 0; i < 2; i++) begin
      if (state_q == ST_PRIME) begin
        filt_d[i] = raw_s[i];
        fcnt_d[i] = 4'd0;
      end else if (raw_s[i] == filt_q[i]) begin
        fcnt_d[i] = 4'd0;
      end else if (fcnt_q[i] == 4'(FILT_LEN - 1)) begin
        filt_d[i] = raw_s[i];
        fcnt_d[i] = 4'd0;
      end else begin
        fcnt_d[i] = fcnt_q[i] + 4'd1;
      end
    end
  end

  // Filter state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_q <= 2'b00;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign s = (state_q == ST_PRIME) ? raw_s : filt_q;
`else
  assign s = raw_s;
`endif

  // Control state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_PRIME;
      prime_cnt_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      prime_cnt_q <= prime_cnt_d;
    end
  end

  // Next state: stay in PRIME until the sync chain has refilled, then track forever
  always_comb begin
    state_d     = state_q;
    prime_cnt_d = prime_cnt_q;
    if (state_q == ST_PRIME) begin
      if (prime_cnt_q == 3'(SYNC_STAGES)) begin
        state_d = ST_TRACK;
      end else begin
        prime_cnt_d = prime_cnt_q + 3'd1;
      end
    end
  end

  // Control outputs: load p on the PRIME exit edge, decode only while tracking
  always_comb begin
    load_p    = (state_q == ST_PRIME) && (prime_cnt_q == 3'(SYNC_STAGES));
    decode_en = (state_q == ST_TRACK);
  end

  // Decoder: single-bit change is a step, double-bit change is an error;
  // for sample {a,b} the move is "up" exactly when new a differs from old b
  always_comb begin
    diff    = s ^ p_q;
    dir_up  = s[1] ^ p_q[0];
    p_d     = p_q;
    step_d  = 1'b0;
    ud_d    = ud_q;
    count_d = count_q;
    err_d   = err_q;
    if (load_p) begin
      p_d = s;
    end
    if (decode_en) begin
      p_d = s;
      if (diff == 2'b11) begin
        err_d = 1'b1;
      end else if (diff != 2'b00) begin
        step_d  = 1'b1;
        ud_d    = dir_up;
        count_d = dir_up ? count_q + 8'd1 : count_q - 8'd1;
      end
    end
    // clr beats a simultaneous step for count; step/ud still report the event
    if (clr) begin
      count_d = 8'd0;
      err_d   = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      qa_sync_q <= '0;
      qb_sync_q <= '0;
      p_q       <= 2'b00;
      step_q    <= 1'b0;
      ud_q      <= 1'b0;
      count_q   <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      qa_sync_q <= qa_sync_d;
      qb_sync_q <= qb_sync_d;
      p_q       <= p_d;
      step_q    <= step_d;
      ud_q      <= ud_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

  assign step  = step_q;
  assign ud    = ud_q;
  assign count = count_q;
  assign err   = err_q;

endmodule
